// File: rtl/frame_dispatch_scheduler.sv
// Round-robin dispatcher that hands whole frames of the shared pixel-group stream to idle image-processor lanes.
// Defining FRAME_DISPATCH_TIMEOUT_EN adds a per-lane drain watchdog (TIMEOUT_CYC); without it DRAIN ends only on CELL_NUM.
module frame_dispatch_scheduler #(
   parameter int IP_AMT      = 4,
   parameter int IP_ADDR_W   = (IP_AMT > 1) ? $clog2(IP_AMT) : 1,
   parameter int PGROUP_NUM  = 2400,
   parameter int CELL_NUM    = 1200,
   parameter int FRAME_CNT_W = 16,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                   s_aclk,
   input  logic                   s_aresetn,
   input  logic                   frame_req_i,
   output logic                   frame_gnt_o,
   output logic                   route_vld_o,
   output logic [IP_ADDR_W-1:0]   route_dest_o,
   input  logic                   pgroup_hs_i,
   input  logic                   pgroup_last_i,
   input  logic [IP_AMT-1:0]      cell_hs_i,
   output logic [2*IP_AMT-1:0]    ip_state_o,
   output logic [FRAME_CNT_W-1:0] frame_cnt_o,
   output logic                   err_o
);
   localparam int PG_W   = $clog2(PGROUP_NUM + 1);
   localparam int CELL_W = $clog2(CELL_NUM + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_DRAIN = 2'b10
   } lane_state_t;

   logic [IP_AMT-1:0]      idle_vec;
   logic [IP_AMT-1:0]      load_vec;
   logic [IP_AMT-1:0]      err_set;
   logic                   gnt_hit;
   logic [IP_ADDR_W-1:0]   gnt_lane;
   logic [IP_ADDR_W-1:0]   rr_next;
   logic                   grant_now;
   logic                   beat;
   logic [PG_W-1:0]        pg_inc;
   logic                   pg_full;
   logic                   load_end;
   logic                   frame_err;

   logic                   gnt_reg;
   logic                   vld_reg;
   logic [IP_ADDR_W-1:0]   dest_reg;
   logic [IP_ADDR_W-1:0]   rr_reg;
   logic [PG_W-1:0]        pg_cnt_reg;
   logic [FRAME_CNT_W-1:0] frame_cnt_reg;
   logic                   err_reg;

   if (IP_AMT < 1 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("frame_dispatch_scheduler: IP_AMT and TIMEOUT_CYC must be >= 1");
   end

   // First idle lane at or after rr_reg; walking k downward lets the nearest lane win.
   always_comb begin
      int                   idx;
      logic [IP_ADDR_W-1:0] lane_w;
      gnt_hit  = 1'b0;
      gnt_lane = '0;
      idx      = 0;
      lane_w   = '0;
      for (int k = IP_AMT - 1; k >= 0; k--) begin
         idx = int'(rr_reg) + k;
         if (idx >= IP_AMT) idx = idx - IP_AMT;
         lane_w = idx[IP_ADDR_W-1:0];
         if (idle_vec[lane_w]) begin
            gnt_hit  = 1'b1;
            gnt_lane = lane_w;
         end
      end
   end

   assign rr_next   = (int'(gnt_lane) == IP_AMT - 1) ? '0 : gnt_lane + 1'b1;
   assign grant_now = frame_req_i && !(|load_vec) && gnt_hit;

   assign beat      = pgroup_hs_i && vld_reg;
   assign pg_inc    = pg_cnt_reg + 1'b1;
   assign pg_full   = (pg_inc == PG_W'(PGROUP_NUM));
   assign load_end  = beat && (pgroup_last_i || pg_full);
   assign frame_err = beat && (pgroup_last_i != pg_full);

   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         gnt_reg       <= 1'b0;
         vld_reg       <= 1'b0;
         dest_reg      <= '0;
         rr_reg        <= '0;
         pg_cnt_reg    <= '0;
         frame_cnt_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         gnt_reg <= grant_now;
         if (grant_now) begin
            vld_reg       <= 1'b1;
            dest_reg      <= gnt_lane;
            rr_reg        <= rr_next;
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
         end else if (load_end) begin
            vld_reg <= 1'b0;
         end
         if (load_end) begin
            pg_cnt_reg <= '0;
         end else if (beat) begin
            pg_cnt_reg <= pg_inc;
         end
         if (frame_err || (|err_set)) begin
            err_reg <= 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < IP_AMT; gi++) begin : g_lane
      lane_state_t       state_reg;
      lane_state_t       state_next;
      logic [CELL_W-1:0] cell_cnt_reg;
      logic [CELL_W-1:0] cell_cnt_next;
      logic              lane_gnt;
      logic              lane_load_end;
      logic              wd_fire;
`ifdef FRAME_DISPATCH_TIMEOUT_EN
      localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
      logic [TO_W-1:0]   idle_cnt_reg;
      logic [TO_W-1:0]   idle_cnt_next;
`endif

      assign lane_gnt      = grant_now && (gnt_lane == IP_ADDR_W'(gi));
      assign lane_load_end = load_end && (dest_reg == IP_ADDR_W'(gi));

      always_comb begin
         state_next    = state_reg;
         cell_cnt_next = cell_cnt_reg;
         wd_fire       = 1'b0;
`ifdef FRAME_DISPATCH_TIMEOUT_EN
         idle_cnt_next = '0;
`endif
         case (state_reg)
            ST_IDLE: begin
               if (lane_gnt) state_next = ST_LOAD;
            end
            ST_LOAD: begin
               if (lane_load_end) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (cell_hs_i[gi]) begin
                  if (cell_cnt_reg == CELL_W'(CELL_NUM - 1)) begin
                     state_next    = ST_IDLE;
                     cell_cnt_next = '0;
                  end else begin
                     cell_cnt_next = cell_cnt_reg + 1'b1;
                  end
               end
`ifdef FRAME_DISPATCH_TIMEOUT_EN
               else if (idle_cnt_reg == TO_W'(TIMEOUT_CYC - 1)) begin
                  state_next    = ST_IDLE;
                  cell_cnt_next = '0;
                  wd_fire       = 1'b1;
               end else begin
                  idle_cnt_next = idle_cnt_reg + 1'b1;
               end
`endif
            end
            default: state_next = ST_IDLE;
         endcase
      end

      always_ff @(posedge s_aclk or negedge s_aresetn) begin
         if (!s_aresetn) begin
            state_reg    <= ST_IDLE;
            cell_cnt_reg <= '0;
`ifdef FRAME_DISPATCH_TIMEOUT_EN
            idle_cnt_reg <= '0;
`endif
         end else begin
            state_reg    <= state_next;
            cell_cnt_reg <= cell_cnt_next;
`ifdef FRAME_DISPATCH_TIMEOUT_EN
            idle_cnt_reg <= idle_cnt_next;
`endif
         end
      end

      assign idle_vec[gi]         = (state_reg == ST_IDLE);
      assign load_vec[gi]         = (state_reg == ST_LOAD);
      assign err_set[gi]          = wd_fire;
      assign ip_state_o[2*gi +: 2] = state_reg;
   end

   assign frame_gnt_o  = gnt_reg;
   assign route_vld_o  = vld_reg;
   assign route_dest_o = dest_reg;
   assign frame_cnt_o  = frame_cnt_reg;
   assign err_o        = err_reg;
endmodule

// File: tb/tb_frame_dispatch_scheduler.sv
// Self-checking bench for frame_dispatch_scheduler: directed scenarios plus randomized traffic against a rule-level model.
module tb_frame_dispatch_scheduler;
   localparam int IP = 4;
   localparam int AW = 2;
   localparam int PG = 2400;
   localparam int CN = 1200;
   localparam int FW = 16;
   localparam int TO = 16;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          req     = 1'b0;
   logic          pg_hs   = 1'b0;
   logic          pg_last = 1'b0;
   logic [IP-1:0] cell_hs = '0;

   logic            gnt;
   logic            vld;
   logic [AW-1:0]   dest;
   logic [2*IP-1:0] ip_state;
   logic [FW-1:0]   fcnt;
   logic            err;
   logic [31:0]     dut_outs;

   frame_dispatch_scheduler #(
      .IP_AMT(IP), .IP_ADDR_W(AW), .PGROUP_NUM(PG), .CELL_NUM(CN),
      .FRAME_CNT_W(FW), .TIMEOUT_CYC(TO)
   ) dut (
      .s_aclk(clk), .s_aresetn(rst_n), .frame_req_i(req), .frame_gnt_o(gnt),
      .route_vld_o(vld), .route_dest_o(dest), .pgroup_hs_i(pg_hs),
      .pgroup_last_i(pg_last), .cell_hs_i(cell_hs), .ip_state_o(ip_state),
      .frame_cnt_o(fcnt), .err_o(err)
   );

   always #5 clk = ~clk;

   assign dut_outs = {3'b000, gnt, vld, dest, ip_state, fcnt, err};

   int checks = 0;
   int errors = 0;
   int frame_no = 0;

   // Model: lane states 0 idle / 1 load / 2 drain, updated once per clock edge from the rules.
   int m_state [IP];
   int m_cell [IP];
   int m_idle [IP];
   int m_pg, m_rr, m_dest, m_cnt;
   bit m_vld, m_gnt, m_err;

   bit            cell_rand  = 1'b0;
   int            cell_prob  = 0;
   logic [IP-1:0] cell_fixed = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
      if (errors >= 25) begin
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < IP; i++) begin
         m_state[i] = 0;
         m_cell[i]  = 0;
         m_idle[i]  = 0;
      end
      m_pg = 0; m_rr = 0; m_dest = 0; m_cnt = 0;
      m_vld = 0; m_gnt = 0; m_err = 0;
   endtask

   task automatic model_step();
      int nstate [IP];
      bit any_load;
      int g;
      if (!rst_n) begin
         model_reset();
         return;
      end
      nstate   = m_state;
      any_load = 0;
      for (int i = 0; i < IP; i++) if (m_state[i] == 1) any_load = 1;
      g = -1;
      if (req && !any_load) begin
         for (int k = 0; k < IP; k++) begin
            if (g < 0 && m_state[(m_rr + k) % IP] == 0) g = (m_rr + k) % IP;
         end
      end
      if (pg_hs && m_vld) begin
         if (pg_last || (m_pg + 1 == PG)) begin
            if (pg_last != (m_pg + 1 == PG)) m_err = 1;
            nstate[m_dest] = 2;
            m_vld = 0;
            m_pg  = 0;
         end else begin
            m_pg++;
         end
      end
      for (int i = 0; i < IP; i++) begin
         if (m_state[i] == 2) begin
            if (cell_hs[i]) begin
               m_idle[i] = 0;
               m_cell[i]++;
               if (m_cell[i] == CN) begin
                  nstate[i] = 0;
                  m_cell[i] = 0;
               end
            end
`ifdef FRAME_DISPATCH_TIMEOUT_EN
            else begin
               m_idle[i]++;
               if (m_idle[i] == TO) begin
                  nstate[i] = 0;
                  m_cell[i] = 0;
                  m_idle[i] = 0;
                  m_err     = 1;
               end
            end
`endif
         end else begin
            m_idle[i] = 0;
         end
      end
      m_gnt = (g >= 0);
      if (g >= 0) begin
         nstate[g] = 1;
         m_dest    = g;
         m_vld     = 1;
         m_rr      = (g + 1) % IP;
         m_cnt     = (m_cnt + 1) % (1 << FW);
      end
      m_state = nstate;
   endtask

   function automatic logic [31:0] model_outs();
      logic [2*IP-1:0] st;
      logic [31:0]     dst;
      logic [31:0]     cnt;
      st = '0;
      for (int i = 0; i < IP; i++) begin
         dst = 32'(m_state[i]);
         st[2*i +: 2] = dst[1:0];
      end
      dst = 32'(m_dest);
      cnt = 32'(m_cnt);
      return {3'b000, m_gnt, m_vld, dst[AW-1:0], st, cnt[FW-1:0], m_err};
   endfunction

   task automatic tick();
      if (cell_rand) begin
         for (int i = 0; i < IP; i++) cell_hs[i] = ($urandom_range(0, 99) < cell_prob);
      end else begin
         cell_hs = cell_fixed;
      end
      @(posedge clk);
      model_step();
      #1;
      chk("cycle", dut_outs, model_outs());
   endtask

   task automatic send_frame(input int nbeats, input int last_at, input int exp_lane,
                             input bit hold_req, output int waited);
      waited = 0;
      req = 1'b1;
      tick();
      while (!m_gnt && waited < 20000) begin
         tick();
         waited++;
      end
      chk("grant_wait", 32'(gnt), 32'd1);
      if (exp_lane >= 0) chk("grant_lane", 32'(dest), 32'(exp_lane));
      req = hold_req;
      frame_no++;
      $display("frame %0d lane=%0d beats=%0d last_at=%0d wait=%0d", frame_no, m_dest, nbeats, last_at, waited);
      for (int b = 1; b <= nbeats; b++) begin
         while ($urandom_range(0, 15) == 0) tick();
         pg_hs   = 1'b1;
         pg_last = (b == last_at);
         tick();
         pg_hs   = 1'b0;
         pg_last = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int w;
      int nb;
      int la;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_gnt", 32'(gnt), 32'd0);
      chk("reset_vld", 32'(vld), 32'd0);
      chk("reset_dest", 32'(dest), 32'd0);
      chk("reset_state", 32'(ip_state), 32'd0);
      chk("reset_cnt", 32'(fcnt), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      tick();

      // Four correct frames with request held: lanes 0..3 in order, then no free lane.
      for (int f = 0; f < IP; f++) send_frame(PG, PG, f, 1'b1, w);
      repeat (50) tick();
      chk("full_no_gnt", 32'(gnt), 32'd0);
      chk("full_cnt", 32'(fcnt), 32'd4);
      chk("full_err", 32'(err), 32'd0);
      chk("full_state", 32'(ip_state), 32'h0000_00AA);

      // Lane 2 drains alone; it is granted the cycle after it returns to idle.
      cell_fixed = 4'b0100;
      repeat (CN - 1) tick();
      chk("lane2_still_drain", 32'(ip_state[5:4]), 32'd2);
      tick();
      chk("lane2_idle", 32'(ip_state[5:4]), 32'd0);
      chk("lane2_no_gnt_same_cycle", 32'(gnt), 32'd0);
      cell_fixed = 4'b1001;
      send_frame(PG, PG, 2, 1'b0, w);
      chk("lane2_grant_latency", 32'(w), 32'd0);
      send_frame(PG, PG, 3, 1'b0, w);
      send_frame(PG, PG, 0, 1'b0, w);
      chk("rr_cnt", 32'(fcnt), 32'd7);

      // Early tlast on beat 2000.
      cell_rand = 1'b1;
      cell_prob = 50;
      send_frame(2000, 2000, -1, 1'b0, w);
      chk("early_err", 32'(err), 32'd1);
      chk("early_vld", 32'(vld), 32'd0);
      chk("early_state", 32'((ip_state >> (2 * m_dest)) & 8'h03), 32'd2);
      send_frame(PG, PG, -1, 1'b0, w);
      chk("after_early_cnt", 32'(fcnt), 32'd9);

      // Missing tlast, then five stray beats.
      cell_rand  = 1'b0;
      cell_fixed = '0;
      do_reset();
      send_frame(PG, 0, 0, 1'b0, w);
      chk("nolast_err", 32'(err), 32'd1);
      chk("nolast_vld", 32'(vld), 32'd0);
      chk("nolast_state", 32'(ip_state), 32'd2);
      pg_hs = 1'b1;
      repeat (5) tick();
      pg_hs = 1'b0;
      chk("extra_state", 32'(ip_state), 32'd2);
      chk("extra_err", 32'(err), 32'd1);
      chk("extra_cnt", 32'(fcnt), 32'd1);

      // Asynchronous reset in the middle of a load.
      send_frame(1000, 0, 1, 1'b0, w);
      chk("midload_state", 32'(ip_state[3:2]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", dut_outs, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_frame(PG, PG, 0, 1'b0, w);

      // Stalled drain on lane 0 after 500 cells.
      do_reset();
      send_frame(PG, PG, 0, 1'b0, w);
      cell_fixed = 4'b0001;
      repeat (500) tick();
      chk("stall_pre_state", 32'(ip_state[1:0]), 32'd2);
      cell_fixed = '0;
      repeat (40) tick();
`ifdef FRAME_DISPATCH_TIMEOUT_EN
      chk("stall_state", 32'(ip_state[1:0]), 32'd0);
      chk("stall_err", 32'(err), 32'd1);
`else
      chk("stall_state", 32'(ip_state[1:0]), 32'd2);
      chk("stall_err", 32'(err), 32'd0);
`endif

      // Randomized frames: correct, early tlast, or missing tlast.
      cell_rand = 1'b1;
      cell_prob = 60;
      for (int f = 0; f < 4; f++) begin
         case ($urandom_range(0, 2))
            0: begin nb = PG; la = PG; end
            1: begin la = $urandom_range(1, PG - 1); nb = la; end
            default: begin nb = PG + $urandom_range(0, 3); la = 0; end
         endcase
         send_frame(nb, la, -1, 1'b0, w);
      end
      repeat (10) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/frame_dispatch_scheduler.md
Name: frame_dispatch_scheduler

Overview:
- Schedules whole frames from the shared AXI-Stream pixel-group path onto IP_AMT image-processor lanes (cell controller, cell buffer, cell cache, cell fetch).
- Tracks each lane through IDLE -> LOAD -> DRAIN and grants the next frame round-robin to an idle lane.
- Drives the routing destination consumed by the AXI controller.
- Only one lane is in LOAD at a time, because the input stream is shared.

Parameters:
- IP_AMT, 4, number of image-processor lanes (>=1)
- IP_ADDR_W, (IP_AMT>1)?$clog2(IP_AMT):1, lane index width
- PGROUP_NUM, 2400, pixel groups per frame (240 rows x 10 groups)
- CELL_NUM, 1200, cells each lane emits per frame
- FRAME_CNT_W, 16, dispatched-frame counter width
- TIMEOUT_CYC, 4096, drain watchdog limit (used only with the optional feature)

Ports:
- s_aclk, in, 1, clock
- s_aresetn, in, 1, reset, asynchronous, active-low
- frame_req_i, in, 1, a new frame's first beat is pending upstream
- frame_gnt_o, out, 1, one-cycle grant; the frame starts loading to route_dest_o
- route_vld_o, out, 1, a lane is in LOAD and the stream may flow
- route_dest_o, out, IP_ADDR_W, lane currently loading (tdest)
- pgroup_hs_i, in, 1, pixel-group beat accepted (tvalid & tready)
- pgroup_last_i, in, 1, tlast qualifying pgroup_hs_i
- cell_hs_i, in, IP_AMT, per-lane cell handshake (cell_valid & cell_ready)
- ip_state_o, out, 2*IP_AMT, per-lane state: 00 IDLE, 01 LOAD, 10 DRAIN
- frame_cnt_o, out, FRAME_CNT_W, frames dispatched; wraps
- err_o, out, 1, sticky framing error

Behaviour:
- Reset (async, s_aresetn=0): all lanes IDLE; frame_gnt_o=0; route_vld_o=0; route_dest_o=0; frame_cnt_o=0; err_o=0; rr pointer=0; all counters=0. Reset mid-frame aborts everything; there is no recovery state.
- Grant rule: when frame_req_i=1, no lane is in LOAD, and at least one lane is IDLE, pick the first IDLE lane searching from rr_ptr upward with wraparound.
  - Registered: next cycle frame_gnt_o=1 for 1 cycle, route_dest_o=lane, route_vld_o=1, lane enters LOAD.
  - rr_ptr <= lane+1, mod IP_AMT.
  - frame_cnt_o increments.
  - Latency: request to grant is 1 cycle.
  - No IDLE lane: no grant; frame_req_i may stay high indefinitely.
- LOAD: the pgroup counter (width $clog2(PGROUP_NUM+1)) counts pgroup_hs_i beats.
  - On a beat with pgroup_last_i=1 and count+1==PGROUP_NUM: lane -> DRAIN, route_vld_o=0 next cycle, counter cleared.
  - pgroup_last_i=1 with count+1!=PGROUP_NUM: err_o<=1; lane still -> DRAIN.
  - count+1==PGROUP_NUM without last: err_o<=1; lane -> DRAIN; further beats are ignored until the next grant.
  - route_dest_o holds its value after LOAD ends, until the next grant.
- DRAIN: a per-lane cell counter counts cell_hs_i[lane]. When the counter reaches CELL_NUM, the lane returns to IDLE next cycle and the counter clears.
  - cell_hs_i on an IDLE or LOAD lane is ignored.
- Simultaneous events:
  - A lane leaving DRAIN->IDLE is not grantable in the same cycle; it is eligible the cycle after.
  - A LOAD->DRAIN transition and a new grant cannot occur in the same cycle; the next grant can come 1 cycle after LOAD ends.
  - Multiple lanes may finish DRAIN in the same cycle; each is independent.
- IP_AMT=1: rr_ptr is constant 0 and route_dest_o is always 0.
- err_o clears only on reset.

Optional Feature:
- Macro FRAME_DISPATCH_TIMEOUT_EN.
- Defined: each lane has an idle-cycle counter in DRAIN, cleared on any cell_hs_i[lane]. When it reaches TIMEOUT_CYC, the lane is forced to IDLE, its cell counter clears, and err_o<=1.
- Undefined: no watchdog logic; DRAIN ends only on the CELL_NUM count, and TIMEOUT_CYC is unused.

Test Plan:
- IP_AMT=4, reset, frame_req_i held 1, all frames correct (2400 beats, last on the 2400th) -> grants to lanes 0,1,2,3 in order. Then no grant until a lane drains 1200 cells. frame_cnt_o=4; err_o=0.
- Lane 2 drains first while lanes 0,1,3 are busy -> the next grant goes to lane 2 one cycle after it reaches IDLE. rr_ptr becomes 3.
- tlast on beat 2000 -> err_o=1, that lane goes DRAIN, route_vld_o=0 the next cycle. A later correct frame still dispatches.
- 2400 beats with no tlast, then 5 extra beats -> err_o=1 at beat 2400, the extra beats do not change state, the lane is in DRAIN.
- Assert s_aresetn=0 mid-LOAD at beat 1000 -> all outputs are at reset values immediately (async). After release, the first grant goes to lane 0.
- With FRAME_DISPATCH_TIMEOUT_EN, TIMEOUT_CYC=16: stall lane 0 after 500 cells -> after 16 idle cycles lane 0 is IDLE, err_o=1. Without the macro, lane 0 stays in DRAIN.
